// File: rtl/stack_seq_pkg.sv
// stack_seq_pkg: definitions shared by the stack push/pop sequencer.
//   state_t     - sequencer FSM states
//   OP_*        - operation codes carried on the 'op' input
//   REG_*       - architectural register indices for SP, LR and PC
//   WORD_BYTES  - byte stride between consecutive stack words
//   lowest_set  - index of the lowest set bit of a 9-bit register list
package stack_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_XFER = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    localparam logic [3:0] REG_SP = 4'd13;
    localparam logic [3:0] REG_LR = 4'd14;
    localparam logic [3:0] REG_PC = 4'd15;

    localparam logic [31:0] WORD_BYTES = 32'd4;

    // Scans downward so the lowest set bit wins; returns 0 for an empty list.
    function automatic logic [3:0] lowest_set(input logic [8:0] mask);
        logic [3:0] idx;
        idx = '0;
        for (int unsigned i = 9; i > 0; i--) begin
            if (mask[i-1]) idx = 4'(i - 1);
        end
        return idx;
    endfunction

endpackage

// File: rtl/stack_seq_if.sv
// stack_seq_if: word-wide memory request bus used by the stack sequencer.
//   mem_req   - request valid, held until acknowledged
//   mem_we    - 1 = write, 0 = read
//   mem_addr  - byte address of the word
//   mem_wdata - write data
//   mem_ack   - completion strobe from memory
//   mem_rdata - read data, valid with mem_ack
// Modports: master (sequencer side), slave (memory side).
interface stack_seq_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/stack_seq_popcnt.sv
// stack_seq_popcnt: combinational population count of a 9-bit register list.
//   bits  - in  9  register list
//   count - out 4  number of set bits (0..9)
module stack_seq_popcnt (
    input  logic [8:0] bits,
    output logic [3:0] count
);

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            count = count + {3'b000, bits[i]};
        end
    end

endmodule

// File: rtl/stack_seq.sv
// stack_seq: multi-register PUSH/POP sequencer.
//   clk, rst         - clock, asynchronous active-high reset
//   start, op        - request strobe and operation (PUSH/POP), sampled in IDLE
//   reg_list         - R0..R7 in bits[7:0], LR (PUSH) / PC (POP) in bit 8
//   sp_in            - stack pointer value at request time
//   rd_data, rd_addr - register-file read data / register index addressed
//   bus              - memory request bus (master side)
//   ld_rd/w_Rd       - register write for POP of R0..R7
//   ld_pc/w_PC       - PC write for POP of bit 8 (bit 0 cleared)
//   ld_sp/w_SP       - SP write-back at completion
//   busy, done, fault- status; done and fault pulse for one cycle in FIN
module stack_seq
    import stack_seq_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          op,
    input  logic [8:0]    reg_list,
    input  logic [31:0]   sp_in,
    input  logic [31:0]   rd_data,
    output logic [3:0]    rd_addr,
    stack_seq_if.master   bus,
    output logic          ld_rd,
    output logic [31:0]   w_Rd,
    output logic          ld_pc,
    output logic [31:0]   w_PC,
    output logic          ld_sp,
    output logic [31:0]   w_SP,
    output logic          busy,
    output logic          done,
    output logic          fault
);

    state_t      state;
    state_t      state_next;

    logic        op_q;
    logic [8:0]  mask_q;      // registers still to transfer
    logic [31:0] sp_q;
    logic [31:0] base_q;
    logic [31:0] addr_q;
    logic [3:0]  cnt_q;       // total transfer count n
    logic        fault_q;

    logic [3:0]  n_calc;
    logic [3:0]  idx;
    logic [8:0]  mask_clr;
    logic        last_xfer;
    logic        misaligned;
    logic [31:0] base_calc;

    stack_seq_popcnt u_popcnt (
        .bits  (mask_q),
        .count (n_calc)
    );

    always_comb begin
        idx        = lowest_set(mask_q);
        mask_clr   = mask_q & (mask_q - 9'd1);   // drop the lowest set bit
        last_xfer  = (mask_clr == '0);
        misaligned = (sp_q[1:0] != 2'b00);
        base_calc  = (op_q == OP_PUSH) ? sp_q - (32'(n_calc) * WORD_BYTES) : sp_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_CALC;
            S_CALC:  state_next = ((n_calc != '0) && !misaligned) ? S_XFER : S_FIN;
            S_XFER:  if (bus.mem_ack && last_xfer) state_next = S_FIN;
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= OP_PUSH;
            mask_q  <= '0;
            sp_q    <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    op_q   <= op;
                    mask_q <= reg_list;
                    sp_q   <= sp_in;
                end
                S_CALC: begin
                    cnt_q   <= n_calc;
                    base_q  <= base_calc;
                    addr_q  <= base_calc;
                    // an empty list never faults, even with a misaligned SP
                    fault_q <= misaligned && (n_calc != '0);
                end
                S_XFER: if (bus.mem_ack) begin
                    mask_q <= mask_clr;
                    addr_q <= addr_q + WORD_BYTES;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_addr       = '0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        ld_rd         = 1'b0;
        w_Rd          = '0;
        ld_pc         = 1'b0;
        w_PC          = '0;
        ld_sp         = 1'b0;
        w_SP          = '0;
        busy          = (state != S_IDLE);
        done          = 1'b0;
        fault         = 1'b0;
        case (state)
            S_XFER: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = addr_q;
                if (op_q == OP_PUSH) begin
                    rd_addr       = (idx == 4'd8) ? REG_LR : idx;
                    bus.mem_we    = 1'b1;
                    bus.mem_wdata = rd_data;
                end else begin
                    rd_addr = (idx == 4'd8) ? REG_PC : idx;
                    if (bus.mem_ack) begin
                        if (idx == 4'd8) begin
                            ld_pc = 1'b1;
                            w_PC  = {bus.mem_rdata[31:1], 1'b0};
                        end else begin
                            ld_rd = 1'b1;
                            w_Rd  = bus.mem_rdata;
                        end
                    end
                end
            end
            S_FIN: begin
                done  = 1'b1;
                fault = fault_q;
                if (!fault_q && (cnt_q != '0)) begin
                    ld_sp = 1'b1;
                    w_SP  = (op_q == OP_PUSH) ? base_q
                                              : sp_q + (32'(cnt_q) * WORD_BYTES);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_stack_seq.sv
// tb_stack_seq: scoreboard bench for stack_seq.
// Expected memory accesses, register writes, SP write-back and done timing
// are queued when an operation is launched and popped as the DUT produces them.
module tb_stack_seq;
    import stack_seq_pkg::*;

    localparam int EV_MWR  = 0;
    localparam int EV_MRD  = 1;
    localparam int EV_LDRD = 2;
    localparam int EV_LDPC = 3;
    localparam int EV_LDSP = 4;
    localparam int EV_DONE = 5;

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [8:0]  reg_list = '0;
    logic [31:0] sp_in = '0;
    logic [31:0] rd_data;
    logic [3:0]  rd_addr;
    logic        ld_rd, ld_pc, ld_sp, busy, done, fault;
    logic [31:0] w_Rd, w_PC, w_SP;
    logic [31:0] regs [16];

    stack_seq_if bus_if ();

    stack_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .reg_list (reg_list),
        .sp_in    (sp_in),
        .rd_data  (rd_data),
        .rd_addr  (rd_addr),
        .bus      (bus_if),
        .ld_rd    (ld_rd),
        .w_Rd     (w_Rd),
        .ld_pc    (ld_pc),
        .w_PC     (w_PC),
        .ld_sp    (ld_sp),
        .w_SP     (w_SP),
        .busy     (busy),
        .done     (done),
        .fault    (fault)
    );

    assign rd_data = regs[rd_addr];

    initial forever #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          req_cycles = 0;
    int          wait_cycles = 0;
    int          waited = 0;
    logic        done_flag = 1'b0;
    ev_t         exp_q [$];
    logic [31:0] rdq [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic push_exp(input int kind, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = kind;
        e.a    = a;
        e.d    = d;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("ev_unexpected", kind, 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind", kind, e.kind);
            check("ev_a", a, e.a);
            check("ev_d", d, e.d);
        end
    endtask

    // Reference model: derives the full event sequence of one operation.
    task automatic expect_op(input logic o, input logic [8:0] l, input logic [31:0] sp, input int w);
        int          n;
        int          k;
        logic [31:0] base, addr, rd;
        n = 0;
        k = 0;
        for (int i = 0; i < 9; i++) if (l[i]) n++;
        if (sp[1:0] != 2'b00 || n == 0) begin
            push_exp(EV_DONE, 2, (n != 0) ? 1 : 0);
            return;
        end
        base = (o == OP_PUSH) ? sp - 32'(4 * n) : sp;
        for (int i = 0; i < 9; i++) begin
            if (l[i]) begin
                addr = base + 32'(4 * k);
                k++;
                if (o == OP_PUSH) begin
                    push_exp(EV_MWR, addr, (i == 8) ? regs[14] : regs[i]);
                end else begin
                    rd = $urandom;
                    rdq.push_back(rd);
                    push_exp(EV_MRD, addr, 0);
                    if (i < 8) push_exp(EV_LDRD, 32'(i), rd);
                    else       push_exp(EV_LDPC, 0, rd & 32'hFFFF_FFFE);
                end
            end
        end
        push_exp(EV_LDSP, 0, (o == OP_PUSH) ? base : sp + 32'(4 * n));
        push_exp(EV_DONE, 32'(n + 2 + n * w), 0);
    endtask

    // Called at posedge+1; start is high for 'hold' cycles, inputs are then scrambled.
    task automatic launch(input logic o, input logic [8:0] l, input logic [31:0] sp, input int hold);
        op         = o;
        reg_list   = l;
        sp_in      = sp;
        start      = 1'b1;
        start_cyc  = cyc;
        done_flag  = 1'b0;
        req_cycles = 0;
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        start    = 1'b0;
        op       = ~o;
        reg_list = 9'h1FF;
        sp_in    = 32'hDEAD_BEE0;
    endtask

    task automatic finish_op(input int max);
        int k;
        k = 0;
        while (!done_flag && k < max) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("done_seen", done_flag, 1);
        @(posedge clk);
        #1;
        check("sb_empty", exp_q.size(), 0);
        exp_q.delete();
        rdq.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ctl"}, {19'd0, bus_if.mem_req, bus_if.mem_we, ld_rd, ld_pc, ld_sp,
                              busy, done, fault, rd_addr}, 0);
        check({tag, "_addr"}, bus_if.mem_addr, 0);
        check({tag, "_wdata"}, bus_if.mem_wdata, 0);
        check({tag, "_w"}, w_Rd | w_PC | w_SP, 0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory responder: acks after 'wait_cycles' wait states, supplies queued read data.
    initial begin
        bus_if.mem_ack   = 1'b0;
        bus_if.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus_if.mem_ack   = 1'b0;
            bus_if.mem_rdata = '0;
            if (!rst && bus_if.mem_req) begin
                if (waited >= wait_cycles) begin
                    bus_if.mem_ack = 1'b1;
                    if (!bus_if.mem_we && rdq.size() > 0) bus_if.mem_rdata = rdq.pop_front();
                    waited = 0;
                end else begin
                    waited++;
                end
            end else begin
                waited = 0;
            end
        end
    end

    // Monitor: samples on the falling edge.
    initial begin
        logic        hold_v;
        logic        hold_we;
        logic [31:0] hold_addr, hold_wdata;
        hold_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_v = 1'b0;
            end else begin
                if (bus_if.mem_req) begin
                    req_cycles++;
                    if (hold_v) begin
                        check("hold_addr", bus_if.mem_addr, hold_addr);
                        check("hold_we", bus_if.mem_we, hold_we);
                        check("hold_wdata", bus_if.mem_wdata, hold_wdata);
                    end
                    if (bus_if.mem_ack) begin
                        observe(bus_if.mem_we ? EV_MWR : EV_MRD, bus_if.mem_addr,
                                bus_if.mem_we ? bus_if.mem_wdata : 32'd0);
                        hold_v = 1'b0;
                    end else begin
                        hold_v     = 1'b1;
                        hold_addr  = bus_if.mem_addr;
                        hold_we    = bus_if.mem_we;
                        hold_wdata = bus_if.mem_wdata;
                    end
                end else begin
                    hold_v = 1'b0;
                end
                if (ld_rd) observe(EV_LDRD, {28'd0, rd_addr}, w_Rd);
                if (ld_pc) observe(EV_LDPC, 0, w_PC);
                if (ld_rd || ld_pc) check("ld_excl", ld_rd & ld_pc, 0);
                if (ld_sp) begin
                    observe(EV_LDSP, 0, w_SP);
                    check("ld_sp_in_fin", done, 1);
                end
                if (fault) check("fault_with_done", done, 1);
                if (done) begin
                    observe(EV_DONE, 32'(cyc - start_cyc), {31'd0, fault});
                    done_flag = 1'b1;
                end
            end
        end
    end

    initial begin
        logic        o;
        logic [8:0]  l;
        logic [31:0] sp;

        for (int i = 0; i < 16; i++) regs[i] = $urandom;

        #1;
        check_zero_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // PUSH {R0,R1,LR} from 0x20000100, zero-wait
        push_exp(EV_MWR, 32'h2000_00F4, regs[0]);
        push_exp(EV_MWR, 32'h2000_00F8, regs[1]);
        push_exp(EV_MWR, 32'h2000_00FC, regs[14]);
        push_exp(EV_LDSP, 0, 32'h2000_00F4);
        push_exp(EV_DONE, 5, 0);
        launch(OP_PUSH, 9'h103, 32'h2000_0100, 1);
        finish_op(40);

        // POP {R4,PC}; start held high into the busy period must be ignored
        rdq.push_back(32'h0000_0011);
        rdq.push_back(32'h0000_0201);
        push_exp(EV_MRD, 32'h2000_00F8, 0);
        push_exp(EV_LDRD, 4, 32'h0000_0011);
        push_exp(EV_MRD, 32'h2000_00FC, 0);
        push_exp(EV_LDPC, 0, 32'h0000_0200);
        push_exp(EV_LDSP, 0, 32'h2000_0100);
        push_exp(EV_DONE, 4, 0);
        launch(OP_POP, 9'h110, 32'h2000_00F8, 3);
        finish_op(40);

        // PUSH {R2} with three wait states
        wait_cycles = 3;
        push_exp(EV_MWR, 32'h2000_00FC, regs[2]);
        push_exp(EV_LDSP, 0, 32'h2000_00FC);
        push_exp(EV_DONE, 6, 0);
        launch(OP_PUSH, 9'h004, 32'h2000_0100, 1);
        finish_op(40);
        check("req_cycles_wait", req_cycles, 4);
        wait_cycles = 0;

        // Empty list
        push_exp(EV_DONE, 2, 0);
        launch(OP_POP, 9'h000, 32'h2000_0100, 1);
        finish_op(20);
        check("req_cycles_empty", req_cycles, 0);

        // Misaligned SP
        push_exp(EV_DONE, 2, 1);
        launch(OP_PUSH, 9'h001, 32'h2000_0102, 1);
        finish_op(20);
        check("req_cycles_misaligned", req_cycles, 0);

        // Reset during the second transfer of a 3-register PUSH
        push_exp(EV_MWR, 32'h2000_01F4, regs[0]);
        launch(OP_PUSH, 9'h00B, 32'h2000_0200, 1);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_zero_outputs("abort");
        repeat (2) @(posedge clk);
        #1;
        check("sb_after_abort", exp_q.size(), 0);
        exp_q.delete();
        rst = 1'b0;
        expect_op(OP_PUSH, 9'h060, 32'h2000_0300, 0);
        launch(OP_PUSH, 9'h060, 32'h2000_0300, 1);
        finish_op(40);

        // Random aligned operations with random wait states
        for (int t = 0; t < 8; t++) begin
            o           = 1'($urandom_range(0, 1));
            l           = 9'($urandom_range(1, 511));
            sp          = $urandom & 32'hFFFF_FFFC;
            wait_cycles = $urandom_range(0, 2);
            expect_op(o, l, sp, wait_cycles);
            launch(o, l, sp, 1);
            finish_op(100);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stack_seq.md
STACK_SEQ -- requirements
Module: stack_seq

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 start  in  1  one-cycle request; accepted only in IDLE.
REQ-004 op  in  1  0=PUSH, 1=POP; sampled with start.
REQ-005 reg_list  in  9  bits[7:0]=R0..R7; bit8=LR for PUSH, PC for POP; sampled with start.
REQ-006 sp_in  in  32  current SP from the register file; sampled with start.
REQ-007 rd_data  in  32  register-file read data for rd_addr, combinational.
REQ-008 rd_addr  out  4  register index being read (PUSH) or written (POP).
REQ-009 mem_req / mem_we / mem_addr[31:0] / mem_wdata[31:0]  out  word memory request.
REQ-010 mem_ack  in  1; mem_rdata  in  32  memory completion and read data.
REQ-011 ld_rd, w_Rd[31:0], ld_pc, w_PC[31:0], ld_sp, w_SP[31:0]  out  register-file write ports.
REQ-012 busy  out  1; done  out  1 (pulse); fault  out  1 (pulse).

Function
REQ-013 FSM states: IDLE, CALC, XFER, FIN. IDLE->CALC on start. CALC->XFER if the list is non-empty and aligned, else CALC->FIN. XFER->FIN after the last ack. FIN->IDLE always.
REQ-014 CALC: n = popcount(reg_list), range 0..9.
- PUSH: base = sp_in - 4n.
- POP: base = sp_in.
- Arithmetic is mod 2^32.
REQ-015 Transfer order: ascending register index, with bit8 last. Transfer k uses address base + 4k.
REQ-016 PUSH: mem_we=1 and mem_wdata=rd_data. rd_addr is the current register, or 14 for bit8.
REQ-017 POP: mem_we=0. On the ack cycle:
- R0..R7: ld_rd=1, w_Rd=mem_rdata, rd_addr = target register.
- bit8: ld_pc=1, w_PC = mem_rdata with bit0 cleared.
REQ-018 Handshake: mem_req stays high throughout XFER. mem_addr, mem_we and mem_wdata are held stable until mem_ack is sampled high. The next transfer is presented in the cycle after the ack. mem_ack outside XFER is ignored.
REQ-019 FIN: done=1 for one cycle. SP write-back is ld_sp=1 with:
- PUSH: w_SP = base.
- POP: w_SP = sp_in + 4n.
REQ-020 Empty reg_list: no memory access, ld_sp=0, done in FIN, fault=0.
REQ-021 sp_in[1:0] != 0: no memory access, ld_sp=0, fault=1 and done=1 together in FIN.
REQ-022 start is ignored while busy. busy=1 in CALC, XFER and FIN.
REQ-023 Latency with zero-wait ack:
- start sampled at cycle 0, CALC at cycle 1, XFER at cycles 2..n+1, FIN/done at cycle n+2.
- Each wait cycle adds one cycle.
REQ-024 At most one of ld_rd/ld_pc is asserted per cycle. ld_sp is asserted only in FIN.

Reset
REQ-025 rst forces IDLE immediately. All outputs go to 0, including rd_addr, mem_addr, w_* and done/fault.
REQ-026 Reset during XFER aborts the operation: no SP update, and memory writes already completed are not undone. start is accepted in the first cycle after rst deasserts.

Structure
REQ-027 Shared package/include: FSM state encodings, OP_PUSH/OP_POP, register indices SP=13, LR=14, PC=15, and word size 4.
REQ-028 One sub-module, stack_seq_popcnt: a 9-bit combinational population count returning 4 bits.
REQ-029 Internal registers: state, op, remaining list mask, base/address, transfer count, and latched sp_in.

Verification
REQ-030 PUSH {R0,R1,LR}, sp=0x20000100, ack every cycle: writes 0x200000F4=R0, 0x200000F8=R1, 0x200000FC=LR; w_SP=0x200000F4; done at cycle 5.
REQ-031 POP {R4,PC}, sp=0x200000F8, rdata 0x00000011 then 0x00000201: R4=0x11; w_PC=0x00000200; w_SP=0x20000100; done at cycle 4.
REQ-032 PUSH {R2} with ack delayed 3 cycles: mem_addr/mem_wdata are stable across the wait cycles, there is exactly one write, and done is at cycle 6.
REQ-033 Empty list: done at cycle 2, mem_req never asserted, ld_sp=0. sp=0x20000102 with {R0}: fault=done=1 at cycle 2 and no access.
REQ-034 rst asserted during the 2nd XFER of a 3-register PUSH: outputs are 0 immediately and ld_sp is never asserted. A new start after release completes normally.
